// File: rtl/uvc_payload_parser.sv
// uvc_payload_parser: strips the fixed-length payload header from the UVC byte stream, checks it and rebuilds 16-bit YUYV words.
// Latency: a pixel word appears 1 cycle after its second byte; header fields and HDR_VLD_O appear 1 cycle after the last header byte.
// Backpressure: none. One byte is consumed on every DVAL_I & VS_I cycle, and DVAL_I gaps only stall the parse.
module uvc_payload_parser #(
  parameter int HEADER_LEN   = 12,
  parameter int PAYLOAD_SIZE = 1024,
  parameter int WIDTH        = 640,
  parameter int HEIGHT       = 480
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [7:0]  DATA_I,
  input  logic        DVAL_I,
  input  logic        VS_I,
  output logic [15:0] PIX_O,
  output logic        PIX_VLD_O,
  output logic        PIX_SOF_O,
  output logic        FID_O,
  output logic        EOF_SEEN_O,
  output logic [31:0] PTS_O,
  output logic [31:0] SCR_O,
  output logic [10:0] SOFCNT_O,
  output logic        HDR_VLD_O,
  output logic        FRAME_DONE_O,
  output logic [3:0]  ERR_O
);

  // Byte index within a payload; it always fits below PAYLOAD_SIZE.
  localparam int              PCW         = (PAYLOAD_SIZE > 2) ? $clog2(PAYLOAD_SIZE) : 1;
  localparam logic [31:0]     FRAME_BYTES = 32'(WIDTH * HEIGHT * 2);
  localparam logic [PCW-1:0]  HDR_LAST    = PCW'(HEADER_LEN - 1);
  localparam logic [PCW-1:0]  PAY_LAST    = PCW'(PAYLOAD_SIZE - 1);
  localparam logic [7:0]      HLEN_BYTE   = 8'(HEADER_LEN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PCW-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [31:0]     data_cnt_q, data_cnt_d;
  logic            vs_q;

  // Header bytes 2..10 are held until byte 11 arrives, so that all fields update together.
  logic [7:0]      hdr_q [2:10];
  logic            fid_q, eof_seen_q, first_pkt_q;
  logic            prev_fid_q, prev_vld_q;
  logic [31:0]     pts_q, scr_q;
  logic [10:0]     sofcnt_q;
  logic            hdr_vld_q, frame_done_q;
  logic [3:0]      err_q;

  logic [7:0]      hi_byte_q;
  logic [15:0]     pix_q;
  logic            pix_vld_q, pix_sof_q, first_word_q;

  logic            acc, vs_rise, vs_fall;
  logic            frame_start, frame_end, hdr_byte, data_byte;

  // Bytes count only inside the frame window. A byte that arrives on the falling-edge cycle is therefore dropped.
  assign acc         = DVAL_I & VS_I;
  assign vs_rise     = VS_I & ~vs_q;
  assign vs_fall     = ~VS_I & vs_q;
  assign frame_start = (state_q == ST_IDLE) & vs_rise;
  assign frame_end   = (state_q != ST_IDLE) & vs_fall;
  assign hdr_byte    = (state_q == ST_HDR) & acc;
  assign data_byte   = (state_q == ST_DATA) & acc;

  // Next state and the payload/data byte counters.
  always_comb begin
    state_d    = state_q;
    pkt_cnt_d  = pkt_cnt_q;
    data_cnt_d = data_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (vs_rise) begin
          state_d    = ST_HDR;
          pkt_cnt_d  = '0;
          data_cnt_d = '0;
        end
      end
      ST_HDR: begin
        if (vs_fall) begin
          state_d = ST_IDLE;
        end else if (acc) begin
          pkt_cnt_d = pkt_cnt_q + PCW'(1);
          if (pkt_cnt_q == HDR_LAST) state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (vs_fall) begin
          state_d = ST_IDLE;
        end else if (acc) begin
          if (data_cnt_q != 32'hFFFF_FFFF) data_cnt_d = data_cnt_q + 32'd1;
          if (pkt_cnt_q == PAY_LAST) begin
            state_d   = ST_HDR;
            pkt_cnt_d = '0;
          end else begin
            pkt_cnt_d = pkt_cnt_q + PCW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and the VS edge detector. vs_q comes out of reset high, so a reset taken
  // while VS_I is high does not produce a false rise. Parsing resumes only after a real low-to-high edge.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q    <= ST_IDLE;
      pkt_cnt_q  <= '0;
      data_cnt_q <= '0;
      vs_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      pkt_cnt_q  <= pkt_cnt_d;
      data_cnt_q <= data_cnt_d;
      vs_q       <= VS_I;
    end
  end

  // Header capture and checks, per-frame error/EOF flags, and the frame-done bookkeeping.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      for (int i = 2; i <= 10; i++) hdr_q[i] <= '0;
      fid_q        <= 1'b0;
      eof_seen_q   <= 1'b0;
      first_pkt_q  <= 1'b0;
      prev_fid_q   <= 1'b0;
      prev_vld_q   <= 1'b0;
      pts_q        <= '0;
      scr_q        <= '0;
      sofcnt_q     <= '0;
      hdr_vld_q    <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= '0;
    end else begin
      hdr_vld_q    <= 1'b0;
      frame_done_q <= 1'b0;

      if (frame_start) begin
        err_q       <= '0;
        eof_seen_q  <= 1'b0;
        first_pkt_q <= 1'b1;
      end

      if (hdr_byte) begin
        for (int i = 2; i <= 10; i++) begin
          if (pkt_cnt_q == PCW'(i)) hdr_q[i] <= DATA_I;
        end
        if ((pkt_cnt_q == '0) && (DATA_I != HLEN_BYTE)) err_q[0] <= 1'b1;
        if (pkt_cnt_q == PCW'(1)) begin
          fid_q <= DATA_I[0];
          // The first header is checked against the previous frame's FID. Later headers are checked against the FID already latched.
          if (!first_pkt_q && (DATA_I[0] != fid_q)) err_q[1] <= 1'b1;
          if (first_pkt_q && prev_vld_q && (DATA_I[0] == prev_fid_q)) err_q[2] <= 1'b1;
          if (DATA_I[1]) eof_seen_q <= 1'b1;
        end
        // Fields are published even when this header failed the length check.
        if (pkt_cnt_q == HDR_LAST) begin
          pts_q       <= {hdr_q[5], hdr_q[4], hdr_q[3], hdr_q[2]};
          scr_q       <= {hdr_q[9], hdr_q[8], hdr_q[7], hdr_q[6]};
          sofcnt_q    <= {DATA_I[2:0], hdr_q[10]};
          hdr_vld_q   <= 1'b1;
          first_pkt_q <= 1'b0;
        end
      end

      if (frame_end) begin
        frame_done_q <= 1'b1;
        if (data_cnt_q != FRAME_BYTES) err_q[3] <= 1'b1;
        prev_fid_q   <= fid_q;
        prev_vld_q   <= 1'b1;
      end
    end
  end

  // Pixel rebuild. Even payload index is the high byte and odd is the low byte. A high byte still pending at frame end is discarded.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      hi_byte_q    <= '0;
      pix_q        <= '0;
      pix_vld_q    <= 1'b0;
      pix_sof_q    <= 1'b0;
      first_word_q <= 1'b0;
    end else begin
      pix_vld_q <= 1'b0;
      pix_sof_q <= 1'b0;
      if (frame_start) first_word_q <= 1'b1;
      if (data_byte) begin
        if (!pkt_cnt_q[0]) begin
          hi_byte_q <= DATA_I;
        end else begin
          pix_q        <= {hi_byte_q, DATA_I};
          pix_vld_q    <= 1'b1;
          pix_sof_q    <= first_word_q;
          first_word_q <= 1'b0;
        end
      end
    end
  end

  assign PIX_O        = pix_q;
  assign PIX_VLD_O    = pix_vld_q;
  assign PIX_SOF_O    = pix_sof_q;
  assign FID_O        = fid_q;
  assign EOF_SEEN_O   = eof_seen_q;
  assign PTS_O        = pts_q;
  assign SCR_O        = scr_q;
  assign SOFCNT_O     = sofcnt_q;
  assign HDR_VLD_O    = hdr_vld_q;
  assign FRAME_DONE_O = frame_done_q;
  assign ERR_O        = err_q;

endmodule

// File: tb/tb_uvc_payload_parser.sv
// tb_uvc_payload_parser: builds random UVC frames (headers plus data) and checks the parser against a frame-level model.
// The model pairs data bytes into words, reads header fields by byte position, and derives the error flags from the frame rules.
module tb_uvc_payload_parser;
  localparam int HL  = 12;
  localparam int PS  = 20;
  localparam int DPP = PS - HL;   // data bytes per full payload
  localparam int FB  = 4 * 2 * 2; // frame bytes for 4x2 pixels

  logic        CLK_I = 1'b0;
  logic        RST_I, DVAL_I, VS_I;
  logic [7:0]  DATA_I;
  logic [15:0] PIX_O;
  logic        PIX_VLD_O, PIX_SOF_O, FID_O, EOF_SEEN_O, HDR_VLD_O, FRAME_DONE_O;
  logic [31:0] PTS_O, SCR_O;
  logic [10:0] SOFCNT_O;
  logic [3:0]  ERR_O;
  logic [100:0] outs;

  uvc_payload_parser #(.HEADER_LEN(HL), .PAYLOAD_SIZE(PS), .WIDTH(4), .HEIGHT(2)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .DATA_I(DATA_I), .DVAL_I(DVAL_I), .VS_I(VS_I),
    .PIX_O(PIX_O), .PIX_VLD_O(PIX_VLD_O), .PIX_SOF_O(PIX_SOF_O), .FID_O(FID_O),
    .EOF_SEEN_O(EOF_SEEN_O), .PTS_O(PTS_O), .SCR_O(SCR_O), .SOFCNT_O(SOFCNT_O),
    .HDR_VLD_O(HDR_VLD_O), .FRAME_DONE_O(FRAME_DONE_O), .ERR_O(ERR_O)
  );

  always #5 CLK_I = ~CLK_I;

  assign outs = {PIX_O, PIX_VLD_O, PIX_SOF_O, FID_O, EOF_SEEN_O, PTS_O, SCR_O,
                 SOFCNT_O, HDR_VLD_O, FRAME_DONE_O, ERR_O};

  int errors = 0;
  int checks = 0;

  // Stimulus: the flat byte stream, plus the data bytes and headers it was built from.
  logic [7:0]  stream[$];
  logic [7:0]  dat[$];
  logic [95:0] hdrs[$];

  // Expected values from the model.
  logic [15:0] exp_pix[$];
  logic [31:0] exp_pts[$], exp_scr[$];
  logic [10:0] exp_sofc[$];
  logic [3:0]  exp_err;
  logic        exp_eof, exp_fid;
  logic        m_prev_fid = 1'b0;
  logic        m_prev_vld = 1'b0;

  // Observed values, sampled on the falling edge.
  logic [15:0] got_pix[$];
  logic        got_sof[$];
  logic [31:0] got_pts[$], got_scr[$];
  logic [10:0] got_sofc[$];
  logic [3:0]  got_err[$];
  logic        got_eof[$], got_fid[$];

  always @(negedge CLK_I) begin
    if (PIX_VLD_O) begin got_pix.push_back(PIX_O); got_sof.push_back(PIX_SOF_O); end
    if (HDR_VLD_O) begin got_pts.push_back(PTS_O); got_scr.push_back(SCR_O); got_sofc.push_back(SOFCNT_O); end
    if (FRAME_DONE_O) begin got_err.push_back(ERR_O); got_eof.push_back(EOF_SEEN_O); got_fid.push_back(FID_O); end
  end

  task automatic clear_mon();
    got_pix.delete(); got_sof.delete(); got_pts.delete(); got_scr.delete();
    got_sofc.delete(); got_err.delete(); got_eof.delete(); got_fid.delete();
  endtask

  // Split ndata bytes into payloads of up to DPP data bytes, each led by a 12-byte header with random fields.
  task automatic make_frame(input int ndata, input logic fid, input logic flip, input logic bad_hlen, input logic eof_last);
    int left, p, chunk;
    logic [95:0] h;
    logic [7:0] b;
    stream.delete(); dat.delete(); hdrs.delete();
    left = ndata; p = 0;
    while (left > 0) begin
      chunk = (left > DPP) ? DPP : left;
      h = {$urandom, $urandom, $urandom};
      h[7:0]  = (bad_hlen && p == 1) ? 8'h0B : 8'(HL);
      h[15:8] = {6'b0, eof_last && (left == chunk), fid ^ (flip && p >= 1)};
      hdrs.push_back(h);
      for (int k = 0; k < HL; k++) stream.push_back(h[8*k +: 8]);
      for (int k = 0; k < chunk; k++) begin
        b = 8'($urandom);
        dat.push_back(b);
        stream.push_back(b);
      end
      p++;
      left -= chunk;
    end
  endtask

  function automatic void model_words();
    exp_pix.delete();
    for (int i = 0; i + 1 < dat.size(); i += 2) exp_pix.push_back({dat[i], dat[i+1]});
  endfunction

  function automatic void model_frame();
    model_words();
    exp_pts.delete(); exp_scr.delete(); exp_sofc.delete();
    exp_err = '0; exp_eof = 1'b0;
    for (int k = 0; k < hdrs.size(); k++) begin
      exp_pts.push_back(hdrs[k][47:16]);
      exp_scr.push_back(hdrs[k][79:48]);
      exp_sofc.push_back({hdrs[k][90:88], hdrs[k][87:80]});
      if (hdrs[k][7:0] != 8'(HL)) exp_err[0] = 1'b1;
      if (k > 0 && hdrs[k][8] != hdrs[k-1][8]) exp_err[1] = 1'b1;
      if (hdrs[k][9]) exp_eof = 1'b1;
    end
    exp_err[2] = m_prev_vld && (hdrs[0][8] == m_prev_fid);
    exp_err[3] = (dat.size() != FB);
    exp_fid    = hdrs[hdrs.size()-1][8];
    m_prev_fid = exp_fid;
    m_prev_vld = 1'b1;
  endfunction

  // gap_mode 0: back-to-back bytes, 1: DVAL toggles every cycle, 2: random idle cycles.
  task automatic drive_bytes(input int nbytes, input int gap_mode);
    for (int i = 0; i < nbytes; i++) begin
      if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 3) == 0)) begin
        DVAL_I = 1'b0; @(posedge CLK_I); #1;
      end
      DATA_I = stream[i]; DVAL_I = 1'b1; @(posedge CLK_I); #1;
    end
    DVAL_I = 1'b0; DATA_I = '0;
  endtask

  task automatic run_frame(input int gap_mode);
    VS_I = 1'b1; @(posedge CLK_I); #1;
    drive_bytes(stream.size(), gap_mode);
    VS_I = 1'b0; repeat (3) @(posedge CLK_I); #1;
  endtask

  task automatic test_reset();
    RST_I = 1'b1; VS_I = 1'b0; DVAL_I = 1'b0; DATA_I = '0;
    repeat (3) @(posedge CLK_I); #1;
    checks++; if (outs !== '0) begin errors++; $display("FAIL reset_hold outs=%h want 0", outs); end
    RST_I = 1'b0; repeat (2) @(posedge CLK_I); #1;
    checks++; if (outs !== '0) begin errors++; $display("FAIL reset_release outs=%h want 0", outs); end
  endtask

  task automatic test_basic();
    int nsof;
    clear_mon();
    make_frame(16, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(0);
    model_frame();
    checks++; if (got_pix.size() != 8) begin errors++; $display("FAIL basic_nwords got=%0d want=8", got_pix.size()); end
    for (int i = 0; i < exp_pix.size() && i < got_pix.size(); i++) begin
      checks++; if (got_pix[i] !== exp_pix[i]) begin errors++; $display("FAIL basic_word%0d got=%h want=%h", i, got_pix[i], exp_pix[i]); end
    end
    nsof = 0; foreach (got_sof[i]) if (got_sof[i]) nsof++;
    checks++; if (nsof != 1 || got_sof.size() == 0 || got_sof[0] !== 1'b1) begin errors++; $display("FAIL basic_sof count=%0d want 1 on word 0", nsof); end
    checks++; if (got_pts.size() != 2) begin errors++; $display("FAIL basic_nhdr got=%0d want=2", got_pts.size()); end
    for (int i = 0; i < exp_pts.size() && i < got_pts.size(); i++) begin
      checks++;
      if ({got_pts[i], got_scr[i], got_sofc[i]} !== {exp_pts[i], exp_scr[i], exp_sofc[i]}) begin
        errors++; $display("FAIL basic_hdr%0d got=%h/%h/%h want=%h/%h/%h", i, got_pts[i], got_scr[i], got_sofc[i], exp_pts[i], exp_scr[i], exp_sofc[i]);
      end
    end
    checks++; if (got_err.size() != 1) begin errors++; $display("FAIL basic_ndone got=%0d want=1", got_err.size()); end
    checks++; if (got_err.size() == 0 || got_err[0] !== 4'b0000) begin errors++; $display("FAIL basic_err got=%p want 0", got_err); end
  endtask

  task automatic test_header_fields();
    logic [95:0] h;
    clear_mon();
    make_frame(16, 1'b0, 1'b0, 1'b0, 1'b0);
    h = 96'h07_62_88_77_66_55_44_33_22_11_02_0C;
    hdrs[0] = h;
    for (int k = 0; k < HL; k++) stream[k] = h[8*k +: 8];
    run_frame(0);
    model_frame();
    checks++; if (got_pts.size() == 0 || got_pts[0] !== 32'h44332211) begin errors++; $display("FAIL hdr_pts got=%p want 44332211", got_pts); end
    checks++; if (got_scr.size() == 0 || got_scr[0] !== 32'h88776655) begin errors++; $display("FAIL hdr_scr got=%p want 88776655", got_scr); end
    checks++; if (got_sofc.size() == 0 || got_sofc[0] !== 11'h762) begin errors++; $display("FAIL hdr_sofcnt got=%p want 762", got_sofc); end
    checks++; if (got_eof.size() != 1 || got_eof[0] !== 1'b1 || got_fid[0] !== 1'b0) begin errors++; $display("FAIL hdr_eof_fid eof=%p fid=%p want 1/0", got_eof, got_fid); end
    checks++; if (got_err.size() != 1 || got_err[0] !== exp_err) begin errors++; $display("FAIL hdr_err got=%p want %b", got_err, exp_err); end
    checks++; if (PTS_O !== exp_pts[exp_pts.size()-1]) begin errors++; $display("FAIL hdr_last_pts got=%h want=%h", PTS_O, exp_pts[exp_pts.size()-1]); end
  endtask

  task automatic test_fid_sequence();
    logic fids [3];
    logic [3:0] want [3];
    fids = '{1'b1, 1'b1, 1'b0};
    want = '{4'b0000, 4'b0100, 4'b0000};
    for (int f = 0; f < 3; f++) begin
      clear_mon();
      make_frame(16, fids[f], 1'b0, 1'b0, 1'b0);
      run_frame(2);
      model_frame();
      checks++;
      if (got_err.size() != 1 || got_err[0] !== want[f] || got_err[0] !== exp_err) begin
        errors++; $display("FAIL fid_seq%0d err got=%p want %b", f, got_err, want[f]);
      end
    end
  endtask

  task automatic test_hdr_errors();
    clear_mon();
    make_frame(16, ~m_prev_fid, 1'b0, 1'b1, 1'b0);
    run_frame(0);
    model_frame();
    checks++; if (got_err.size() != 1 || got_err[0] !== 4'b0001 || got_err[0] !== exp_err) begin errors++; $display("FAIL hlen_err got=%p want 0001", got_err); end
    checks++; if (got_pts.size() != 2) begin errors++; $display("FAIL hlen_hdr_vld got=%0d want=2", got_pts.size()); end
    clear_mon();
    make_frame(16, ~m_prev_fid, 1'b1, 1'b0, 1'b0);
    run_frame(0);
    model_frame();
    checks++; if (got_err.size() != 1 || got_err[0] !== 4'b0010 || got_err[0] !== exp_err) begin errors++; $display("FAIL fid_flip_err got=%p want 0010", got_err); end
  endtask

  task automatic test_short_frame();
    clear_mon();
    make_frame(15, ~m_prev_fid, 1'b0, 1'b0, 1'b1);
    run_frame(2);
    model_frame();
    checks++; if (got_pix.size() != 7) begin errors++; $display("FAIL short_nwords got=%0d want=7", got_pix.size()); end
    for (int i = 0; i < exp_pix.size() && i < got_pix.size(); i++) begin
      checks++; if (got_pix[i] !== exp_pix[i]) begin errors++; $display("FAIL short_word%0d got=%h want=%h", i, got_pix[i], exp_pix[i]); end
    end
    checks++; if (got_err.size() != 1 || got_err[0] !== 4'b1000) begin errors++; $display("FAIL short_err got=%p want 1000", got_err); end
    checks++; if (got_eof.size() != 1 || got_eof[0] !== 1'b1) begin errors++; $display("FAIL short_eof got=%p want 1", got_eof); end
  endtask

  task automatic test_reset_mid_frame();
    clear_mon();
    make_frame(16, 1'(~m_prev_fid), 1'b0, 1'b0, 1'b0);
    model_words();
    // 35 bytes = header, 8 data, header, 3 data -> 11 data bytes -> 5 words.
    VS_I = 1'b1; @(posedge CLK_I); #1;
    drive_bytes(35, 1);
    RST_I = 1'b1; #1;
    checks++; if (outs !== '0) begin errors++; $display("FAIL rst_mid_async outs=%h want 0", outs); end
    @(posedge CLK_I); #1; RST_I = 1'b0;
    m_prev_vld = 1'b0;
    checks++; if (got_pix.size() != 5) begin errors++; $display("FAIL rst_mid_nwords got=%0d want=5", got_pix.size()); end
    for (int i = 0; i < 5 && i < got_pix.size(); i++) begin
      checks++; if (got_pix[i] !== exp_pix[i]) begin errors++; $display("FAIL rst_mid_word%0d got=%h want=%h", i, got_pix[i], exp_pix[i]); end
    end
    repeat (2) @(posedge CLK_I); #1;
    VS_I = 1'b0; repeat (3) @(posedge CLK_I); #1;
    checks++; if (got_err.size() != 0 || outs !== '0) begin errors++; $display("FAIL rst_mid_quiet dones=%0d outs=%h want 0/0", got_err.size(), outs); end
    clear_mon();
    make_frame(16, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
    run_frame(2);
    model_frame();
    checks++; if (got_pix.size() != 8) begin errors++; $display("FAIL rst_next_nwords got=%0d want=8", got_pix.size()); end
    for (int i = 0; i < exp_pix.size() && i < got_pix.size(); i++) begin
      checks++; if (got_pix[i] !== exp_pix[i]) begin errors++; $display("FAIL rst_next_word%0d got=%h want=%h", i, got_pix[i], exp_pix[i]); end
    end
    checks++; if (got_err.size() != 1 || got_err[0] !== 4'b0000) begin errors++; $display("FAIL rst_next_err got=%p want 0", got_err); end
  endtask

  task automatic test_back_to_back();
    int nd, gm;
    for (int f = 0; f < 5; f++) begin
      clear_mon();
      nd = $urandom_range(10, 24);
      gm = $urandom_range(0, 2);
      make_frame(nd, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'($urandom_range(0, 1)));
      run_frame(gm);
      model_frame();
      checks++; if (got_pix.size() != exp_pix.size()) begin errors++; $display("FAIL b2b%0d_nwords got=%0d want=%0d", f, got_pix.size(), exp_pix.size()); end
      for (int i = 0; i < exp_pix.size() && i < got_pix.size(); i++) begin
        checks++; if (got_pix[i] !== exp_pix[i]) begin errors++; $display("FAIL b2b%0d_word%0d got=%h want=%h", f, i, got_pix[i], exp_pix[i]); end
      end
      checks++; if (got_pts.size() != exp_pts.size()) begin errors++; $display("FAIL b2b%0d_nhdr got=%0d want=%0d", f, got_pts.size(), exp_pts.size()); end
      checks++;
      if (got_err.size() != 1 || got_err[0] !== exp_err || got_eof[0] !== exp_eof || got_fid[0] !== exp_fid) begin
        errors++; $display("FAIL b2b%0d_done err=%p eof=%p fid=%p want %b/%b/%b", f, got_err, got_eof, got_fid, exp_err, exp_eof, exp_fid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_header_fields();
    test_fid_sequence();
    test_hdr_errors();
    test_short_frame();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
